// File: rtl/ep_dbi_pkg.sv
// ep_dbi_pkg: shared DBI responder types, widths and the byte-lane merge helper.
package ep_dbi_pkg;
  localparam int DBI_DW = 32;
  localparam int DBI_BE_W = 4;
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_WAIT = 4'b0010,
    ST_ACK  = 4'b0100,
    ST_HOLD = 4'b1000
  } state_t;
  function automatic logic [DBI_DW-1:0] be_merge(input logic [DBI_DW-1:0] old_w,
                                                 input logic [DBI_DW-1:0] new_w,
                                                 input logic [DBI_BE_W-1:0] be);
    logic [DBI_DW-1:0] r;
    r = old_w;
    for (int i = 0; i < DBI_BE_W; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/ep_dbi_lbc_bank.sv
// ep_dbi_lbc_bank: DEPTH x 32 register bank with byte-lane writes, async read, cleared on reset.
module ep_dbi_lbc_bank import ep_dbi_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                core_clk,
  input  logic                pcie_rst_n,
  input  logic                we,
  input  logic [DBI_BE_W-1:0] be,
  input  logic [AW-1:0]       idx,
  input  logic [DBI_DW-1:0]   wdata,
  output logic [DBI_DW-1:0]   rdata
);
  logic [DBI_DW-1:0] mem_q [DEPTH];
  logic [DBI_DW-1:0] mem_d [DEPTH];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[idx] = be_merge(mem_q[idx], wdata, be);
  end
  always_ff @(posedge core_clk or negedge pcie_rst_n)
    if (!pcie_rst_n) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else mem_q <= mem_d;
  assign rdata = mem_q[idx];
endmodule

// File: rtl/ep_dbi_lbc_resp.sv
// ep_dbi_lbc_resp: DBI local-bus responder with config and mask banks.
// Define EP_DBI_LBC_UNMAPPED_NOACK_EN to leave unmapped accesses unacked (initiator times out).
module ep_dbi_lbc_resp import ep_dbi_pkg::*; #(
  parameter int          DEPTH   = 16,
  parameter int          ACK_LAT = 2,
  parameter logic [15:0] RO_MASK = 16'h0003
) (
  input  logic                core_clk,
  input  logic                pcie_rst_n,
  input  logic [DBI_DW-1:0]   dbi_din,
  input  logic [DBI_BE_W-1:0] dbi_wr,
  input  logic [31:0]         dbi_addr,
  input  logic                dbi_cs,
  input  logic                dbi_cs2_exp,
  input  logic                dbi_ro_wr_disable,
  output logic                lbc_dbi_ack,
  output logic [DBI_DW-1:0]   lbc_dbi_dout,
  output logic [15:0]         acc_cnt,
  output logic                busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [63:0] RO_EXT = 64'(RO_MASK);
  state_t state_q, state_d;
  logic [3:0] lat_q, lat_d;
  logic [DBI_DW-1:0] din_q, din_d, dout_q, dout_d, cfg_rd, msk_rd, rdata;
  logic [DBI_BE_W-1:0] wr_q, wr_d;
  logic [29:0] addr_q, addr_d;
  logic cs2_q, cs2_d, rowd_q, rowd_d, ack_q, ack_d;
  logic [15:0] cnt_q, cnt_d;
  logic cap, mapped, ack_ok, do_ack, we, cfg_we, msk_we, unused_ok;
  logic [AW-1:0] idx;
  assign unused_ok = ^dbi_addr[1:0];
  assign idx = addr_q[AW-1:0];
  assign mapped = addr_q[29:AW] == '0;
`ifdef EP_DBI_LBC_UNMAPPED_NOACK_EN
  assign ack_ok = mapped;
`else
  assign ack_ok = 1'b1;
`endif
  always_ff @(posedge core_clk or negedge pcie_rst_n)
    if (!pcie_rst_n) begin
      state_q <= ST_IDLE;
      lat_q <= '0;
      din_q <= '0;
      wr_q <= '0;
      addr_q <= '0;
      cs2_q <= 1'b0;
      rowd_q <= 1'b0;
      ack_q <= 1'b0;
      dout_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q <= lat_d;
      din_q <= din_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      cs2_q <= cs2_d;
      rowd_q <= rowd_d;
      ack_q <= ack_d;
      dout_q <= dout_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = dbi_cs ? ST_WAIT : ST_IDLE;
      ST_WAIT: state_d = !dbi_cs ? ST_IDLE : (lat_q == '0 ? ST_ACK : ST_WAIT);
      ST_ACK:  state_d = ST_HOLD;
      ST_HOLD: state_d = dbi_cs ? ST_HOLD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  // Request fields are frozen at capture; later bus changes only matter at the next IDLE.
  always_comb begin
    cap = state_q == ST_IDLE && dbi_cs;
    din_d = cap ? dbi_din : din_q;
    wr_d = cap ? dbi_wr : wr_q;
    addr_d = cap ? dbi_addr[31:2] : addr_q;
    cs2_d = cap ? dbi_cs2_exp : cs2_q;
    rowd_d = cap ? dbi_ro_wr_disable : rowd_q;
    lat_d = cap ? 4'(ACK_LAT - 1) : (state_q == ST_WAIT && lat_q != '0) ? lat_q - 4'd1 : lat_q;
  end
  always_comb begin
    do_ack = state_q == ST_ACK && ack_ok;
    we = do_ack && mapped && wr_q != '0;
    cfg_we = we && !cs2_q && !(rowd_q && RO_EXT[idx]);
    msk_we = we && cs2_q;
    rdata = cs2_q ? msk_rd : cfg_rd;
    ack_d = do_ack;
    dout_d = do_ack && mapped && wr_q == '0 ? rdata : '0;
    cnt_d = do_ack && cnt_q != 16'hFFFF ? cnt_q + 16'd1 : cnt_q;
  end
  ep_dbi_lbc_bank #(.DEPTH(DEPTH)) u_cfg (
    .core_clk(core_clk), .pcie_rst_n(pcie_rst_n), .we(cfg_we), .be(wr_q),
    .idx(idx), .wdata(din_q), .rdata(cfg_rd)
  );
  ep_dbi_lbc_bank #(.DEPTH(DEPTH)) u_msk (
    .core_clk(core_clk), .pcie_rst_n(pcie_rst_n), .we(msk_we), .be(wr_q),
    .idx(idx), .wdata(din_q), .rdata(msk_rd)
  );
  assign lbc_dbi_ack = ack_q;
  assign lbc_dbi_dout = dout_q;
  assign acc_cnt = cnt_q;
  assign busy = state_q != ST_IDLE;
endmodule

// File: tb/tb_ep_dbi_lbc_resp.sv
// tb_ep_dbi_lbc_resp: directed and randomized checks of ep_dbi_lbc_resp against a bank/counter model.
module tb_ep_dbi_lbc_resp;
  localparam int ACK_LAT = 2;
  localparam logic [15:0] RO_MASK = 16'h0003;
  logic core_clk = 1'b0, pcie_rst_n = 1'b0;
  logic [31:0] dbi_din = '0, dbi_addr = '0, lbc_dbi_dout;
  logic [3:0] dbi_wr = '0;
  logic dbi_cs = 1'b0, dbi_cs2_exp = 1'b0, dbi_ro_wr_disable = 1'b0, lbc_dbi_ack, busy;
  logic [15:0] acc_cnt;
  int checks = 0, errors = 0;
  logic [31:0] cfg [16];
  logic [31:0] msk [16];
  int m_cnt;

  always #5 core_clk = ~core_clk;

  ep_dbi_lbc_resp #(.DEPTH(16), .ACK_LAT(ACK_LAT), .RO_MASK(RO_MASK)) dut (
    .core_clk(core_clk), .pcie_rst_n(pcie_rst_n), .dbi_din(dbi_din), .dbi_wr(dbi_wr),
    .dbi_addr(dbi_addr), .dbi_cs(dbi_cs), .dbi_cs2_exp(dbi_cs2_exp),
    .dbi_ro_wr_disable(dbi_ro_wr_disable), .lbc_dbi_ack(lbc_dbi_ack),
    .lbc_dbi_dout(lbc_dbi_dout), .acc_cnt(acc_cnt), .busy(busy)
  );

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      cfg[i] = '0;
      msk[i] = '0;
    end
    m_cnt = 0;
  endtask

  // Reference: banks as arrays, unmapped = any address bit above the 16-word window.
  task automatic model(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                       input logic c2, input logic ro, output logic eack, output logic [31:0] edout);
    int idx;
    logic mapped;
    idx = int'(a[5:2]);
    mapped = a[31:6] == '0;
`ifdef EP_DBI_LBC_UNMAPPED_NOACK_EN
    eack = mapped;
`else
    eack = 1'b1;
`endif
    edout = '0;
    if (eack && m_cnt < 65535) m_cnt++;
    if (eack && mapped) begin
      if (w == 4'h0) edout = c2 ? msk[idx] : cfg[idx];
      else if (c2) begin
        for (int b = 0; b < 4; b++) if (w[b]) msk[idx][8*b +: 8] = d[8*b +: 8];
      end else if (!(ro && RO_MASK[idx])) begin
        for (int b = 0; b < 4; b++) if (w[b]) cfg[idx][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  // Drives one access for ncyc sampled edges, scrambling the bus after capture, then drops cs.
  task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                        input logic c2, input logic ro, input int ncyc,
                        output int nack, output int lat, output logic [31:0] rd);
    nack = 0;
    lat = -1;
    rd = '0;
    @(negedge core_clk);
    dbi_addr = a; dbi_wr = w; dbi_din = d; dbi_cs2_exp = c2; dbi_ro_wr_disable = ro; dbi_cs = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge core_clk); #1;
      if (lbc_dbi_ack) begin
        nack++;
        if (lat < 0) lat = k;
        rd = lbc_dbi_dout;
      end
      @(negedge core_clk);
      if (k == 0) begin
        dbi_addr = $urandom; dbi_din = $urandom; dbi_wr = 4'($urandom);
        dbi_cs2_exp = ~c2; dbi_ro_wr_disable = ~ro;
      end
    end
    dbi_cs = 1'b0;
    @(posedge core_clk); #1;
    if (lbc_dbi_ack) nack++;
  endtask

  task automatic test_reset();
    checks++; if (lbc_dbi_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", lbc_dbi_ack); end
    checks++; if (lbc_dbi_dout !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", lbc_dbi_dout); end
    checks++; if (acc_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", acc_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_write_read();
    int n, l; logic [31:0] r, e; logic ea;
    model(32'h10, 4'hF, 32'hA5A5_0001, 0, 0, ea, e);
    access(32'h10, 4'hF, 32'hA5A5_0001, 0, 0, ACK_LAT + 3, n, l, r);
    checks++; if (n !== 1) begin errors++; $display("FAIL wr_ack_count got %0d want 1", n); end
    checks++; if (l !== ACK_LAT + 1) begin errors++; $display("FAIL wr_latency got %0d want %0d", l, ACK_LAT + 1); end
    model(32'h10, 4'h0, 0, 0, 0, ea, e);
    access(32'h10, 4'h0, 0, 0, 0, ACK_LAT + 3, n, l, r);
    checks++; if (r !== 32'hA5A5_0001) begin errors++; $display("FAIL rd_after_wr got %h want a5a50001", r); end
    checks++; if (acc_cnt !== 16'd2) begin errors++; $display("FAIL cnt_after_two got %0d want 2", acc_cnt); end
  endtask

  task automatic test_byte_lanes();
    int n, l; logic [31:0] r, e; logic ea;
    model(32'h14, 4'hF, 32'hFFFF_FFFF, 0, 0, ea, e);
    access(32'h14, 4'hF, 32'hFFFF_FFFF, 0, 0, ACK_LAT + 3, n, l, r);
    model(32'h14, 4'b0011, 32'h0000_1234, 0, 0, ea, e);
    access(32'h14, 4'b0011, 32'h0000_1234, 0, 0, ACK_LAT + 3, n, l, r);
    model(32'h14, 4'h0, 0, 0, 0, ea, e);
    access(32'h14, 4'h0, 0, 0, 0, ACK_LAT + 3, n, l, r);
    checks++; if (r !== 32'hFFFF_1234) begin errors++; $display("FAIL byte_merge got %h want ffff1234", r); end
  endtask

  task automatic test_ro();
    int n, l; logic [31:0] r, e; logic ea;
    model(32'h4, 4'hF, 32'h1, 0, 1, ea, e);
    access(32'h4, 4'hF, 32'h1, 0, 1, ACK_LAT + 3, n, l, r);
    checks++; if (n !== 1) begin errors++; $display("FAIL ro_write_acked got %0d want 1", n); end
    model(32'h4, 4'h0, 0, 0, 0, ea, e);
    access(32'h4, 4'h0, 0, 0, 0, ACK_LAT + 3, n, l, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL ro_blocked got %h want 0", r); end
    model(32'h4, 4'hF, 32'h1, 0, 0, ea, e);
    access(32'h4, 4'hF, 32'h1, 0, 0, ACK_LAT + 3, n, l, r);
    model(32'h4, 4'h0, 0, 0, 0, ea, e);
    access(32'h4, 4'h0, 0, 0, 0, ACK_LAT + 3, n, l, r);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL ro_open got %h want 1", r); end
  endtask

  task automatic test_mask_bank();
    int n, l; logic [31:0] r, e; logic ea;
    model(32'h10, 4'hF, 32'hFFF0_0000, 1, 1, ea, e);
    access(32'h10, 4'hF, 32'hFFF0_0000, 1, 1, ACK_LAT + 3, n, l, r);
    model(32'h10, 4'h0, 0, 0, 0, ea, e);
    access(32'h10, 4'h0, 0, 0, 0, ACK_LAT + 3, n, l, r);
    checks++; if (r !== 32'hA5A5_0001) begin errors++; $display("FAIL cfg_untouched got %h want a5a50001", r); end
    model(32'h10, 4'h0, 0, 1, 0, ea, e);
    access(32'h10, 4'h0, 0, 1, 0, ACK_LAT + 3, n, l, r);
    checks++; if (r !== 32'hFFF0_0000) begin errors++; $display("FAIL mask_read got %h want fff00000", r); end
    model(32'h4, 4'hF, 32'h77, 1, 1, ea, e);
    access(32'h4, 4'hF, 32'h77, 1, 1, ACK_LAT + 3, n, l, r);
    model(32'h4, 4'h0, 0, 1, 0, ea, e);
    access(32'h4, 4'h0, 0, 1, 0, ACK_LAT + 3, n, l, r);
    checks++; if (r !== 32'h77) begin errors++; $display("FAIL mask_ignores_ro got %h want 77", r); end
  endtask

  task automatic test_hold_abandon();
    int n, l, stray; logic [31:0] r, e; logic ea; logic [15:0] c0;
    model(32'h8, 4'h0, 0, 0, 0, ea, e);
    access(32'h8, 4'h0, 0, 0, 0, ACK_LAT + 13, n, l, r);
    checks++; if (n !== 1) begin errors++; $display("FAIL hold_single_ack got %0d want 1", n); end
    c0 = acc_cnt;
    stray = 0;
    @(negedge core_clk);
    dbi_addr = 32'h18; dbi_wr = 4'hF; dbi_din = 32'hDEAD_BEEF; dbi_cs2_exp = 0; dbi_ro_wr_disable = 0; dbi_cs = 1;
    @(posedge core_clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy got %b want 1", busy); end
    @(negedge core_clk); dbi_cs = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge core_clk); #1;
      if (lbc_dbi_ack) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL abandon_no_ack got %0d want 0", stray); end
    checks++; if (acc_cnt !== c0) begin errors++; $display("FAIL abandon_cnt got %0d want %0d", acc_cnt, c0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abandon_idle got %b want 0", busy); end
    model(32'h18, 4'h0, 0, 0, 0, ea, e);
    access(32'h18, 4'h0, 0, 0, 0, ACK_LAT + 3, n, l, r);
    checks++; if (r !== e) begin errors++; $display("FAIL abandon_no_write got %h want %h", r, e); end
  endtask

  task automatic test_unmapped();
    int n, l; logic [31:0] r, e; logic ea;
    model(32'h1000, 4'h0, 0, 0, 0, ea, e);
    access(32'h1000, 4'h0, 0, 0, 0, 250, n, l, r);
    checks++; if (n !== int'(ea)) begin errors++; $display("FAIL unmapped_ack got %0d want %0d", n, ea); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_dout got %h want 0", r); end
    checks++; if (acc_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL unmapped_cnt got %0d want %0d", acc_cnt, m_cnt); end
  endtask

  task automatic test_random();
    int n, l; logic [31:0] a, d, r, e; logic [3:0] w; logic c2, ro, ea;
    for (int i = 0; i < 80; i++) begin
      a = {26'd0, 4'($urandom), 2'($urandom)};
      if ($urandom_range(7) == 0) a[12] = 1'b1;
      w = ($urandom_range(2) == 0) ? 4'h0 : 4'($urandom);
      d = $urandom; c2 = 1'($urandom); ro = 1'($urandom);
      model(a, w, d, c2, ro, ea, e);
      access(a, w, d, c2, ro, ACK_LAT + 3, n, l, r);
      checks++; if (n !== int'(ea)) begin errors++; $display("FAIL rnd_ack[%0d] got %0d want %0d", i, n, ea); end
      checks++; if (ea && l !== ACK_LAT + 1) begin errors++; $display("FAIL rnd_lat[%0d] got %0d want %0d", i, l, ACK_LAT + 1); end
      checks++; if (r !== e) begin errors++; $display("FAIL rnd_dout[%0d] a=%h got %h want %h", i, a, r, e); end
      checks++; if (acc_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, acc_cnt, m_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    int n, l; logic [31:0] r, e; logic ea;
    model(32'h8, 4'hF, 32'h1234_5678, 0, 0, ea, e);
    access(32'h8, 4'hF, 32'h1234_5678, 0, 0, ACK_LAT + 3, n, l, r);
    @(negedge core_clk);
    dbi_addr = 32'h8; dbi_wr = 4'h0; dbi_cs = 1;
    @(posedge core_clk);
    @(negedge core_clk); pcie_rst_n = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (lbc_dbi_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ack got %b want 0", lbc_dbi_ack); end
    @(negedge core_clk); dbi_cs = 0; pcie_rst_n = 1;
    model_clear();
    checks++; if (acc_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d want 0", acc_cnt); end
    model(32'h8, 4'h0, 0, 0, 0, ea, e);
    access(32'h8, 4'h0, 0, 0, 0, ACK_LAT + 3, n, l, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_mid_cleared got %h want 0", r); end
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge core_clk);
    #1;
    test_reset();
    @(negedge core_clk); pcie_rst_n = 1;
    test_write_read();
    test_byte_lanes();
    test_ro();
    test_mask_bank();
    test_hold_abandon();
    test_unmapped();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
